spmv_row_lanes: RTL
===================

SPMV_ROW_LANES -- requirements
Module: spmv_row_lanes

Interface
REQ-001 SHALL have parameter DW, default 32: signed width of sparse values and dense-vector elements.
REQ-002 SHALL have parameter AW, default 10: column-index, dense-address and row-index width.
REQ-003 SHALL have parameter LANES, default 2: nonzero elements accepted per input beat.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1: input-beat handshake; a beat transfers when both are high at a clk edge.
REQ-007 SHALL have port in_val  input  LANES*DW: signed nonzero values, lane k at bits [k*DW +: DW].
REQ-008 SHALL have port in_col  input  LANES*AW: column index per lane.
REQ-009 SHALL have port in_mask  input  LANES: lane-valid mask; masked lanes contribute 0.
REQ-010 SHALL have port in_last  input  1: beat ends the current row.
REQ-011 SHALL have port addrext  output  LANES*AW: dense-vector read address per lane.
REQ-012 SHALL have port dense_data  input  LANES*DW: dense element per lane, valid one cycle after addrext.
REQ-013 SHALL have ports out_valid output 1 and out_ready input 1: row-result handshake.
REQ-014 SHALL have port dataout  output  2*DW: signed row dot-product.
REQ-015 SHALL have port out_row  output  AW: index of the row on dataout.
REQ-016 SHALL have port zeros  output  1: emitted row had no unmasked lanes.
REQ-017 SHALL have port overflow  output  1: emitted row result was saturated.

Function
REQ-018 SHALL be a 3-stage pipeline: S1 registers beat and drives addrext; S2 registers LANES signed products DW x DW -> 2*DW; S3 sums products into a 2*DW+8-bit signed accumulator.
REQ-019 SHALL assert out_valid on the clock edge 3 cycles after acceptance of an in_last beat, with dataout = accumulator including that beat.
REQ-020 SHALL clear the accumulator and the zero-tracking flag in the same edge that loads a row result into the output register.
REQ-021 SHALL hold dataout, out_row, zeros, overflow stable while out_valid=1 and out_ready=0.
REQ-022 SHALL stall all stages (global enable low) while out_valid=1 and out_ready=0; in_ready=0 during stall; addrext held so dense_data stays valid.
REQ-023 SHALL keep in_ready=1 when not stalled; out_valid=1 with out_ready=1 is not a stall.
REQ-024 SHALL treat in_last beat with in_mask=0 as valid: empty row emits dataout=0, zeros=1.
REQ-025 SHALL increment out_row by 1 per emitted row, wrapping 2^AW-1 -> 0.
REQ-026 SHALL drive addrext lanes with in_mask=0 to 0 and ignore their dense_data.

Reset
REQ-027 SHALL on rst low clear immediately: in_ready=0, out_valid=0, dataout=0, out_row=0, zeros=0, overflow=0, addrext=0, pipeline valids, accumulator.
REQ-028 SHALL discard any partial row on reset mid-operation; in_ready=1 from first edge after rst deasserts.

Configuration
REQ-029 SHALL, with SPMV_SAT_EN defined, saturate accumulator to signed 2*DW range on output and set overflow=1 when clamped.
REQ-030 SHALL, without SPMV_SAT_EN, output low 2*DW accumulator bits (two's-complement wrap) with overflow tied 0.

Structure
REQ-031 SHALL place default DW/AW/LANES, guard width 8 and lane-slice helper constants in package spmv_pkg.
REQ-032 SHALL instantiate per-lane sub-module spmv_lane_mul (mask-gated registered signed multiply), LANES copies.

Verification
REQ-033 SHALL cover: one beat vals {3,-2}, cols {5,7}, dense[5]=10, dense[7]=4, last -> dataout=22, out_row=0, out_valid 3 cycles later.
REQ-034 SHALL cover: row of 3 beats, mask 2'b01 on last, all products 1 -> dataout=5, zeros=0.
REQ-035 SHALL cover: empty row (mask 0, last) -> dataout=0, zeros=1, out_row increments.
REQ-036 SHALL cover: out_ready=0 for 4 cycles while streaming -> in_ready=0, outputs stable, no result lost or duplicated.
REQ-037 SHALL cover: 4 beats each 0x7FFFFFFF x 0x7FFFFFFF, both lanes -> SPMV_SAT_EN: dataout=0x7FFFFFFFFFFFFFFF, overflow=1; without: wrapped value, overflow=0.
REQ-038 SHALL cover: rst low mid-row then 1025 empty rows -> first row index 0, out_row wraps to 0 after 1023.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared constants and lane-slice helpers for the sparse matrix-vector row engine.
package spmv_pkg;

    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned AW_DEF    = 10;
    localparam int unsigned LANES_DEF = 2;
    localparam int unsigned GUARD_W   = 8;

    // Low bit of lane k inside a flat bus whose lanes are w bits wide.
    function automatic int unsigned lane_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/spmv_lane_mul.sv
// One lane of the product stage: mask-gated registered signed multiply.
module spmv_lane_mul
    import spmv_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_mask,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [2*DW-1:0] o_prod
);

    localparam int unsigned PW = 2 * DW;

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] r_prod;

    assign w_a    = PW'($signed(i_a));
    assign w_b    = PW'($signed(i_b));
    assign o_prod = r_prod;

    // Register the full-width product; masked lanes contribute zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
        end else if (i_en) begin
            r_prod <= i_mask ? (w_a * w_b) : '0;
        end
    end

endmodule

// File: rtl/spmv_row_lanes.sv
// Sparse row dot-product engine: S1 beat/address, S2 lane products, S3 accumulate,
// then a held output register. Optional SPMV_SAT_EN clamps results to 2*DW signed.
module spmv_row_lanes
    import spmv_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_val,
    input  logic [LANES*AW-1:0] in_col,
    input  logic [LANES-1:0]    in_mask,
    input  logic                in_last,
    output logic [LANES*AW-1:0] addrext,
    input  logic [LANES*DW-1:0] dense_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DW-1:0]     dataout,
    output logic [AW-1:0]       out_row,
    output logic                zeros,
    output logic                overflow
);

    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned ACCW = PW + GUARD_W;

    logic                    r_active;
    logic                    w_stall;
    logic                    w_en;
    logic                    w_accept;
    logic [LANES*AW-1:0]     w_addr;

    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic [LANES-1:0]        r_s1_mask;
    logic [LANES*DW-1:0]     r_s1_val;
    logic [LANES*AW-1:0]     r_addr;

    logic                    r_s2_valid;
    logic                    r_s2_last;
    logic                    r_s2_any;
    logic [PW-1:0]           w_prod [LANES];
    logic signed [ACCW-1:0]  w_prod_sum;
    logic signed [ACCW-1:0]  w_contrib;
    logic                    w_any_in;

    logic signed [ACCW-1:0]  r_acc;
    logic                    r_any;
    logic                    r_s3_last;

    logic                    r_out_valid;
    logic [PW-1:0]           r_dataout;
    logic [AW-1:0]           r_out_row;
    logic [AW-1:0]           r_row_cnt;
    logic                    r_zeros;
    logic                    r_overflow;
    logic [PW-1:0]           w_out_data;
    logic                    w_out_ovf;

    // Only a held result that nobody takes freezes the pipe.
    assign w_stall  = r_out_valid & ~out_ready;
    assign w_en     = ~w_stall;
    assign in_ready = r_active & ~w_stall;
    assign w_accept = in_valid & in_ready;

    assign addrext   = r_addr;
    assign out_valid = r_out_valid;
    assign dataout   = r_dataout;
    assign out_row   = r_out_row;
    assign zeros     = r_zeros;
    assign overflow  = r_overflow;

    // Masked lanes present address 0 so their dense read is harmless.
    always_comb begin
        w_addr = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (in_mask[k]) begin
                w_addr[k*AW +: AW] = in_col[k*AW +: AW];
            end
        end
    end

    // S1: capture the accepted beat and drive the dense-vector addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_val   <= '0;
            r_addr     <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_en) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_last <= in_last;
                    r_s1_mask <= in_mask;
                    r_s1_val  <= in_val;
                    r_addr    <= w_addr;
                end
            end
        end
    end

    // S2: per-lane products against the dense element returned for S1's address.
    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        spmv_lane_mul #(
            .DW (DW)
        ) u_mul (
            .clk    (clk),
            .rst_n  (rst),
            .i_en   (w_en),
            .i_mask (r_s1_mask[k] & r_s1_valid),
            .i_a    (r_s1_val[lane_lo(k, DW) +: DW]),
            .i_b    (dense_data[lane_lo(k, DW) +: DW]),
            .o_prod (w_prod[k])
        );
    end

    // S2 side-band: beat valid, row end and whether any lane was live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_any   <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid & r_s1_last;
            r_s2_any   <= r_s1_valid & (|r_s1_mask);
        end
    end

    // Sign-extended sum of this beat's lane products.
    always_comb begin
        w_prod_sum = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            w_prod_sum = w_prod_sum + ACCW'($signed(w_prod[k]));
        end
        w_contrib = r_s2_valid ? w_prod_sum : '0;
        w_any_in  = r_s2_valid & r_s2_any;
    end

`ifdef SPMV_SAT_EN
    // Clamp to the 2*DW signed range when the guard bits disagree with the sign.
    always_comb begin
        w_out_data = r_acc[PW-1:0];
        w_out_ovf  = 1'b0;
        if (r_acc[ACCW-1:PW-1] != {(GUARD_W + 1){r_acc[ACCW-1]}}) begin
            w_out_ovf  = 1'b1;
            w_out_data = r_acc[ACCW-1] ? {1'b1, {(PW - 1){1'b0}}} : {1'b0, {(PW - 1){1'b1}}};
        end
    end
`else
    logic w_unused_guard;

    // Two's-complement wrap: only the low 2*DW bits leave the block.
    always_comb begin
        w_out_data = r_acc[PW-1:0];
        w_out_ovf  = 1'b0;
    end

    assign w_unused_guard = ^r_acc[ACCW-1:PW];
`endif

    // S3 accumulate and output load; a finished row restarts the accumulator
    // with whatever beat of the next row arrives on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_any       <= 1'b0;
            r_s3_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_dataout   <= '0;
            r_out_row   <= '0;
            r_row_cnt   <= '0;
            r_zeros     <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_en) begin
            r_s3_last <= r_s2_last;
            if (r_s3_last) begin
                r_out_valid <= 1'b1;
                r_dataout   <= w_out_data;
                r_overflow  <= w_out_ovf;
                r_zeros     <= ~r_any;
                r_out_row   <= r_row_cnt;
                r_row_cnt   <= r_row_cnt + AW'(1);
                r_acc       <= w_contrib;
                r_any       <= w_any_in;
            end else begin
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
                r_acc <= r_acc + w_contrib;
                r_any <= r_any | w_any_in;
            end
        end
    end

endmodule
